// File: rtl/exception_controller.sv
// Timer / UART-rx exception controller: latches request edges, arbitrates (timer first),
// redirects IF to the handler vector with EPC capture, and returns to the EPC on eret.
module exception_controller #(
  parameter logic [31:0] TIMER_VECTOR = 32'h8000_0000,
  parameter logic [31:0] RX_VECTOR    = 32'h8000_0008,
  parameter int          CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             timer_req,
  input  logic             rx_req,
  input  logic [1:0]       irq_enable,
  input  logic [31:0]      if_pc,
  input  logic [31:0]      if_pc_next,
  input  logic             if_is_jump,
  input  logic             eret,
  output logic             redirect,
  output logic [31:0]      target_pc,
  output logic             squash,
  output logic [1:0]       ack,
  output logic [1:0]       cause,
  output logic [31:0]      epc,
  output logic [CNT_W-1:0] exc_count,
  output logic             err_eret
);

  typedef enum logic [1:0] {
    ST_USER   = 2'd0,
    ST_ENTER  = 2'd1,
    ST_KERNEL = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       req_prev_q, req_prev_d;
  logic [1:0]       pending_q, pending_d;
  logic [1:0]       sel_q, sel_d;
  logic [31:0]      epc_q, epc_d;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic [1:0]       req_vec;
  logic [1:0]       req_edge;
  logic [1:0]       eligible;
  logic [1:0]       take;

  assign req_vec  = {rx_req, timer_req};
  assign req_edge = req_vec & ~req_prev_q;
  // Kernel-mode PC blocks taking, but never blocks latching into pending.
  assign eligible = pending_q & irq_enable & {2{~if_pc[31]}};

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    epc_d      = epc_q;
    cause_d    = cause_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    take       = 2'b00;
    redirect   = 1'b0;
    target_pc  = 32'h0;
    squash     = 1'b0;
    ack        = 2'b00;
    req_prev_d = req_vec;

    case (state_q)
      ST_USER: begin
        if (eret) err_d = 1'b1;
        if (eligible != 2'b00) begin
          sel_d   = eligible[0] ? 2'b01 : 2'b10;
          state_d = ST_ENTER;
        end
      end
      ST_ENTER: begin
        if (eret) err_d = 1'b1;
        redirect  = 1'b1;
        target_pc = sel_q[0] ? TIMER_VECTOR : RX_VECTOR;
        squash    = if_is_jump;
        ack       = sel_q;
        take      = sel_q;
        // A jump in IF means the next PC is a delay slot; return to the jump itself.
        epc_d     = if_is_jump ? if_pc : if_pc_next;
        cause_d   = sel_q;
        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        state_d   = ST_KERNEL;
      end
      ST_KERNEL: begin
        if (eret) begin
          redirect  = 1'b1;
          target_pc = epc_q;
          cause_d   = 2'b00;
          state_d   = ST_USER;
        end
      end
      default: state_d = ST_USER;
    endcase

    pending_d = (pending_q & ~take) | req_edge;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_USER;
      req_prev_q <= 2'b00;
      pending_q  <= 2'b00;
      sel_q      <= 2'b00;
      epc_q      <= 32'h0;
      cause_q    <= 2'b00;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_prev_q <= req_prev_d;
      pending_q  <= pending_d;
      sel_q      <= sel_d;
      epc_q      <= epc_d;
      cause_q    <= cause_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  assign cause     = cause_q;
  assign epc       = epc_q;
  assign exc_count = cnt_q;
  assign err_eret  = err_q;

endmodule

// File: tb/tb_exception_controller.sv
// Bench for exception_controller: directed scenarios with literal expectations, then
// randomized traffic scored against a cycle-level behavioural model.
module tb_exception_controller;

  localparam int          CNT_W = 2;
  localparam logic [31:0] TV    = 32'h8000_0000;
  localparam logic [31:0] RV    = 32'h8000_0008;
  localparam int          EXP_W = 1 + 32 + 1 + 2 + 2 + 32 + CNT_W + 1;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             timer_req = 1'b0;
  logic             rx_req = 1'b0;
  logic [1:0]       irq_enable = 2'b11;
  logic [31:0]      if_pc = 32'h0;
  logic [31:0]      if_pc_next = 32'h0;
  logic             if_is_jump = 1'b0;
  logic             eret = 1'b0;
  logic             redirect;
  logic [31:0]      target_pc;
  logic             squash;
  logic [1:0]       ack;
  logic [1:0]       cause;
  logic [31:0]      epc;
  logic [CNT_W-1:0] exc_count;
  logic             err_eret;

  int n_tests = 0;
  int n_fails = 0;

  logic [EXP_W-1:0] exp_q[$];

  // Model state: phase 0 = running user code, 1 = entry cycle, 2 = inside handler.
  int          m_phase;
  logic [1:0]  m_pend;
  logic [1:0]  m_prev;
  logic [1:0]  m_sel;
  logic [31:0] m_epc;
  logic [1:0]  m_cause;
  int          m_cnt;
  logic        m_err;
  logic        last_was_enter;

  exception_controller #(
    .TIMER_VECTOR(TV),
    .RX_VECTOR   (RV),
    .CNT_W       (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .timer_req (timer_req),
    .rx_req    (rx_req),
    .irq_enable(irq_enable),
    .if_pc     (if_pc),
    .if_pc_next(if_pc_next),
    .if_is_jump(if_is_jump),
    .eret      (eret),
    .redirect  (redirect),
    .target_pc (target_pc),
    .squash    (squash),
    .ack       (ack),
    .cause     (cause),
    .epc       (epc),
    .exc_count (exc_count),
    .err_eret  (err_eret)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_pend  = 2'b00;
    m_prev  = 2'b00;
    m_sel   = 2'b00;
    m_epc   = 32'h0;
    m_cause = 2'b00;
    m_cnt   = 0;
    m_err   = 1'b0;
    last_was_enter = 1'b0;
  endtask

  // Expected outputs for the current cycle, then advance the model across the next edge.
  task automatic model_step();
    logic [1:0]  req, edg, elig, take;
    logic        e_red, e_sq;
    logic [31:0] e_tgt;
    logic [1:0]  e_ack;
    req   = {rx_req, timer_req};
    edg   = req & ~m_prev;
    e_red = 1'b0;
    e_tgt = 32'h0;
    e_sq  = 1'b0;
    e_ack = 2'b00;
    last_was_enter = (m_phase == 1);
    if (m_phase == 1) begin
      e_red = 1'b1;
      e_tgt = (m_sel == 2'b01) ? TV : RV;
      e_sq  = if_is_jump;
      e_ack = m_sel;
    end else if (m_phase == 2 && eret) begin
      e_red = 1'b1;
      e_tgt = m_epc;
    end
    exp_q.push_back({e_red, e_tgt, e_sq, e_ack, m_cause, m_epc, CNT_W'(m_cnt), m_err});

    take = (m_phase == 1) ? m_sel : 2'b00;
    if (eret && m_phase != 2) m_err = 1'b1;
    if (m_phase == 1) begin
      m_epc   = if_is_jump ? if_pc : if_pc_next;
      m_cause = m_sel;
      if (m_cnt < (1 << CNT_W) - 1) m_cnt = m_cnt + 1;
      m_phase = 2;
    end else if (m_phase == 2) begin
      if (eret) begin
        m_phase = 0;
        m_cause = 2'b00;
      end
    end else begin
      elig = m_pend & irq_enable & (if_pc[31] ? 2'b00 : 2'b11);
      if (elig != 2'b00) begin
        m_sel   = elig[0] ? 2'b01 : 2'b10;
        m_phase = 1;
      end
    end
    m_pend = (m_pend & ~take) | edg;
    m_prev = req;
  endtask

  // Driver tasks
  task automatic drive_cycle(input logic treq, input logic rreq, input logic [1:0] en,
                             input logic [31:0] pc, input logic [31:0] pcn,
                             input logic jmp, input logic er);
    @(posedge clk);
    #1;
    timer_req  = treq;
    rx_req     = rreq;
    irq_enable = en;
    if_pc      = pc;
    if_pc_next = pcn;
    if_is_jump = jmp;
    eret       = er;
    #1;
    model_step();
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    model_step();
  endtask

  task automatic mid_reset();
    void'(exp_q.pop_back());
    reset = 1'b0;
    #1;
    chk("rst_redirect", 32'(redirect), 32'h0);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_target", target_pc, 32'h0);
    chk("rst_squash", 32'(squash), 32'h0);
    chk("rst_epc", epc, 32'h0);
    chk("rst_cause", 32'(cause), 32'h0);
    chk("rst_count", 32'(exc_count), 32'h0);
    chk("rst_err", 32'(err_eret), 32'h0);
    model_reset();
    release_reset();
  endtask

  // Scoreboard: compare every scored cycle away from the active edge.
  always @(negedge clk) begin
    logic [EXP_W-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("redirect",  32'(redirect),  32'(e[EXP_W-1]));
      chk("target_pc", target_pc,      e[EXP_W-2 -: 32]);
      chk("squash",    32'(squash),    32'(e[EXP_W-34]));
      chk("ack",       32'(ack),       32'(e[EXP_W-35 -: 2]));
      chk("cause",     32'(cause),     32'(e[EXP_W-37 -: 2]));
      chk("epc",       epc,            e[CNT_W+32 -: 32]);
      chk("exc_count", 32'(exc_count), 32'(e[CNT_W:1]));
      chk("err_eret",  32'(err_eret),  32'(e[0]));
    end
  end

  // Stimulus
  initial begin
    logic        t, r, j, er;
    logic [1:0]  en;
    logic [31:0] pc;
    model_reset();
    repeat (3) @(posedge clk);
    release_reset();

    drive_cycle(0, 0, 2'b11, 32'h0040_0000, 32'h0040_0004, 0, 0);
    chk("init_redirect", 32'(redirect), 32'h0);
    chk("init_target", target_pc, 32'h0);
    chk("init_epc", epc, 32'h0);
    chk("init_count", 32'(exc_count), 32'h0);
    chk("init_err", 32'(err_eret), 32'h0);

    // Timer entry: edge, selection, then the entry cycle.
    drive_cycle(1, 0, 2'b11, 32'h0040_0010, 32'h0040_0014, 0, 0);
    chk("t1_no_early", 32'(redirect), 32'h0);
    drive_cycle(1, 0, 2'b11, 32'h0040_0010, 32'h0040_0014, 0, 0);
    chk("t1_no_early2", 32'(redirect), 32'h0);
    drive_cycle(1, 0, 2'b11, 32'h0040_0010, 32'h0040_0014, 0, 0);
    chk("t1_redirect", 32'(redirect), 32'h1);
    chk("t1_target", target_pc, 32'h8000_0000);
    chk("t1_ack", 32'(ack), 32'h1);
    chk("t1_squash", 32'(squash), 32'h0);
    drive_cycle(1, 0, 2'b11, 32'h8000_0000, 32'h8000_0004, 0, 0);
    chk("t1_epc", epc, 32'h0040_0014);
    chk("t1_cause", 32'(cause), 32'h1);
    chk("t1_count", 32'(exc_count), 32'h1);
    drive_cycle(1, 0, 2'b11, 32'h8000_0004, 32'h8000_0008, 0, 1);
    chk("t1_eret_redirect", 32'(redirect), 32'h1);
    chk("t1_eret_target", target_pc, 32'h0040_0014);

    // eret while in user mode is flagged and ignored.
    drive_cycle(1, 0, 2'b11, 32'h0040_0014, 32'h0040_0018, 0, 1);
    chk("t5_user_eret_redirect", 32'(redirect), 32'h0);
    chk("t5_cause_cleared", 32'(cause), 32'h0);
    drive_cycle(0, 0, 2'b11, 32'h0040_0018, 32'h0040_001c, 0, 0);
    chk("t5_err_set", 32'(err_eret), 32'h1);
    drive_cycle(0, 0, 2'b11, 32'h0040_001c, 32'h0040_0020, 0, 0);
    chk("t5_err_sticky", 32'(err_eret), 32'h1);

    // Simultaneous timer and rx; entry coincides with a jump.
    drive_cycle(1, 1, 2'b11, 32'h0040_0020, 32'h0040_0024, 0, 0);
    drive_cycle(1, 1, 2'b11, 32'h0040_0020, 32'h0040_0024, 0, 0);
    drive_cycle(1, 1, 2'b11, 32'h0040_0020, 32'h0040_0040, 1, 0);
    chk("t2_ack_timer", 32'(ack), 32'h1);
    chk("t3_squash", 32'(squash), 32'h1);
    drive_cycle(1, 1, 2'b11, 32'h8000_0000, 32'h8000_0004, 0, 0);
    chk("t3_epc", epc, 32'h0040_0020);
    chk("t2_count", 32'(exc_count), 32'h2);
    drive_cycle(1, 1, 2'b11, 32'h8000_0004, 32'h8000_0008, 0, 1);
    chk("t2_eret_target", target_pc, 32'h0040_0020);
    drive_cycle(1, 1, 2'b11, 32'h0040_0020, 32'h0040_0024, 0, 0);
    chk("t2_select_quiet", 32'(redirect), 32'h0);
    drive_cycle(1, 1, 2'b11, 32'h0040_0024, 32'h0040_0028, 0, 0);
    chk("t2_rx_target", target_pc, 32'h8000_0008);
    chk("t2_rx_ack", 32'(ack), 32'h2);
    drive_cycle(1, 1, 2'b11, 32'h8000_0008, 32'h8000_000c, 0, 1);

    // Randomized traffic, with occasional resets landing in the entry cycle.
    t = 1'b1; r = 1'b1; en = 2'b11;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) t = ~t;
      if ($urandom_range(0, 9) == 0) r = ~r;
      if ($urandom_range(0, 11) == 0) en = 2'($urandom_range(0, 3));
      pc = $urandom;
      pc[31] = ($urandom_range(0, 3) == 0);
      j  = 1'($urandom_range(0, 1));
      er = ($urandom_range(0, 4) == 0);
      drive_cycle(t, r, en, pc, pc + 32'd4, j, er);
      if (last_was_enter && $urandom_range(0, 3) == 0) mid_reset();
    end

    @(negedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule
